// File: rtl/bp_pkg.sv
// Shared types and constants for the global-history predictor checkpoint controller.
package bp_pkg;

  localparam int GHR_LENGTH_DEF = 8;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b11;
  localparam logic [1:0] CNT_ST  = 2'b10;

  localparam logic [1:0] PHT_INIT_VAL = CNT_WT;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // Checkpoint layout at the default GHR width; the controller packs entries in this order.
  typedef struct packed {
    logic [GHR_LENGTH_DEF-1:0] ghr;
    logic                      pred;
    logic [GHR_LENGTH_DEF-1:0] pc_idx;
  } ckpt_t;

endpackage

// File: rtl/bp_ghr_checkpoint_ctrl_fifo.sv
// bp_ckpt_fifo: in-order checkpoint queue with push, pop and a clear that wins over both.
module bp_ckpt_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_push_ok = i_push && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clr && !i_rst) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

  assign o_head  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/bp_ghr_checkpoint_ctrl.sv
// GHR checkpoint / PHT sequencing controller. Define BP_STATS_EN to add the
// saturating branch and mispredict counters.
//
// state   | meaning
// INIT    | PHT sweep, one weakly-taken write per cycle; no allocation
// RUN     | checkpoints pushed at decode, popped on resolve in M
// RECOVER | one cycle after a mispredict while wrong-path decode drains
module bp_ghr_checkpoint_ctrl
  import bp_pkg::*;
#(
  parameter int GHR_LENGTH = GHR_LENGTH_DEF,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_valid,
  input  logic [GHR_LENGTH-1:0] i_alloc_ghr,
  input  logic                  i_alloc_pred,
  input  logic [31:0]           i_alloc_pc,
  output logic                  o_alloc_ready,
  input  logic                  i_resolve_valid,
  input  logic                  i_resolve_taken,
  output logic                  o_restore_valid,
  output logic [GHR_LENGTH-1:0] o_restore_ghr,
  output logic                  o_flush_req,
  output logic                  o_pht_we,
  output logic                  o_pht_init,
  output logic [GHR_LENGTH-1:0] o_pht_idx,
  output logic                  o_pht_taken,
  input  logic                  i_inv_req,
  output logic                  o_init_busy,
`ifdef BP_STATS_EN
  output logic [31:0]           o_stat_branches,
  output logic [31:0]           o_stat_mispred,
`endif
  output logic                  o_protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * GHR_LENGTH + 1;
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [GHR_LENGTH-1:0] r_sweep;
  logic [GHR_LENGTH-1:0] w_sweep_nxt;

  logic [EW-1:0]         w_din;
  logic [EW-1:0]         w_head;
  logic [GHR_LENGTH-1:0] w_head_ghr;
  logic                  w_head_pred;
  logic [GHR_LENGTH-1:0] w_head_pc;
  logic                  w_full;
  logic                  w_empty;
  logic [AW:0]           w_occ;
  logic [AW:0]           w_occ_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_clr;
  logic                  w_mispred;
  logic                  w_pht_we;
  logic                  w_pht_init;
  logic [GHR_LENGTH-1:0] w_pht_idx;
  logic                  w_pht_taken;
  logic                  w_restore;
  logic [GHR_LENGTH-1:0] w_restore_ghr;
  logic                  w_perr;
  logic                  w_unused_pc;

  assign w_din       = {i_alloc_ghr, i_alloc_pred, i_alloc_pc[GHR_LENGTH+1:2]};
  assign w_head_ghr  = w_head[EW-1:GHR_LENGTH+1];
  assign w_head_pred = w_head[GHR_LENGTH];
  assign w_head_pc   = w_head[GHR_LENGTH-1:0];
  assign w_mispred   = (i_resolve_taken != w_head_pred);
  assign w_unused_pc = ^{i_alloc_pc[31:GHR_LENGTH+2], i_alloc_pc[1:0]};

  bp_ckpt_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_occ)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_sweep_nxt   = r_sweep;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_clr         = 1'b0;
    w_pht_we      = 1'b0;
    w_pht_init    = 1'b0;
    w_pht_idx     = '0;
    w_pht_taken   = 1'b0;
    w_restore     = 1'b0;
    w_restore_ghr = '0;
    w_perr        = o_protocol_err;

    if (i_inv_req) begin
      w_state_nxt = INIT;
      w_sweep_nxt = '0;
      w_clr       = 1'b1;
    end else begin
      case (r_state)
        INIT: begin
          w_pht_we    = 1'b1;
          w_pht_init  = 1'b1;
          w_pht_idx   = r_sweep;
          w_sweep_nxt = r_sweep + 1'b1;
          if (r_sweep == '1) w_state_nxt = RUN;
        end
        RUN: begin
          if (i_resolve_valid) begin
            if (w_empty) begin
              w_perr = 1'b1;
            end else begin
              w_pop       = 1'b1;
              w_pht_we    = 1'b1;
              w_pht_idx   = w_head_ghr ^ w_head_pc;
              w_pht_taken = i_resolve_taken;
              if (w_mispred) begin
                w_restore     = 1'b1;
                w_restore_ghr = {w_head_ghr[GHR_LENGTH-2:0], i_resolve_taken};
                w_clr         = 1'b1;
                w_state_nxt   = RECOVER;
              end
            end
          end
          // Younger entries are wrong-path after a mispredict, so a same-cycle push dies too.
          w_push = i_alloc_valid && !w_clr && (!w_full || w_pop);
        end
        RECOVER: w_state_nxt = RUN;
        default: w_state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    if (w_clr) begin
      w_occ_nxt = '0;
    end else begin
      w_occ_nxt = w_occ + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= INIT;
      r_sweep         <= '0;
      o_alloc_ready   <= 1'b0;
      o_restore_valid <= 1'b0;
      o_restore_ghr   <= '0;
      o_flush_req     <= 1'b0;
      o_pht_we        <= 1'b0;
      o_pht_init      <= 1'b0;
      o_pht_idx       <= '0;
      o_pht_taken     <= 1'b0;
      o_init_busy     <= 1'b1;
      o_protocol_err  <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_sweep         <= w_sweep_nxt;
      o_alloc_ready   <= (w_state_nxt == RUN) && (w_occ_nxt != OCC_FULL);
      o_restore_valid <= w_restore;
      o_restore_ghr   <= w_restore_ghr;
      o_flush_req     <= w_restore;
      o_pht_we        <= w_pht_we;
      o_pht_init      <= w_pht_init;
      o_pht_idx       <= w_pht_idx;
      o_pht_taken     <= w_pht_taken;
      o_init_busy     <= (w_state_nxt == INIT);
      o_protocol_err  <= w_perr;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_branches <= '0;
      o_stat_mispred  <= '0;
    end else begin
      if (w_pop && (o_stat_branches != '1)) o_stat_branches <= o_stat_branches + 32'd1;
      if (w_restore && (o_stat_mispred != '1)) o_stat_mispred <= o_stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: doc/bp_ghr_checkpoint_ctrl.md
Name: bp_ghr_checkpoint_ctrl

Overview:
Controller that sequences the global-history branch predictor.
- Checkpoints the GHR for every in-flight branch at decode, in an in-order queue.
- Retires the oldest checkpoint when the branch resolves in M. Emits the PHT update index, and on a mispredict emits the GHR restore value and a flush request.
- Owns the PHT initialisation sweep after reset or an invalidate request.

Parameters:
GHR_LENGTH, 8, GHR width; PHT has 2^GHR_LENGTH entries.
DEPTH, 4, checkpoint queue entries; power of two, at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
alloc_valid  in  1  branch in D, not stalled; push checkpoint
alloc_ghr  in  GHR_LENGTH  GHR value before the speculative shift
alloc_pred  in  1  predicted direction from D
alloc_pc  in  32  branch PC
alloc_ready  out  1  queue can accept a push this cycle
resolve_valid  in  1  branch in M; pop oldest checkpoint
resolve_taken  in  1  actual direction
restore_valid  out  1  one-cycle pulse: load GHR with restore_ghr
restore_ghr  out  GHR_LENGTH  {ckpt_ghr[GHR_LENGTH-2:0], resolve_taken}
flush_req  out  1  one-cycle pulse: flush younger pipeline stages
pht_we  out  1  PHT write/update strobe
pht_init  out  1  with pht_we: write weakly-taken (2'b11) instead of counter update
pht_idx  out  GHR_LENGTH  PHT index
pht_taken  out  1  direction for the counter update
inv_req  in  1  request a PHT re-initialisation
init_busy  out  1  sweep in progress
protocol_err  out  1  sticky; set on resolve with an empty queue in RUN

Behaviour:
- All outputs are registered (one-cycle latency from the inputs).
- Reset values: state=INIT, sweep counter=0, queue empty, every output 0 except init_busy=1.
- States: INIT, RUN, RECOVER.
- INIT:
  - Each cycle: pht_we=1, pht_init=1, pht_idx=counter; counter increments.
  - After index 2^GHR_LENGTH-1 is written, go to RUN. Sweep lasts exactly 2^GHR_LENGTH cycles.
  - alloc_ready=0. resolve_valid is ignored; no error is flagged.
- RUN:
  - alloc_ready = !full.
  - Push when alloc_valid && alloc_ready. Each entry stores {ghr, pred, pc[GHR_LENGTH+1:2]}.
  - On resolve_valid, pop head and output pht_we=1, pht_init=0, pht_idx = head.ghr ^ head.pc, pht_taken=resolve_taken.
  - Mispredict when resolve_taken != head.pred:
    - Pulse restore_valid and flush_req.
    - Clear the whole queue; all younger entries are wrong-path.
    - Go to RECOVER.
- RECOVER:
  - Lasts 1 cycle; alloc_ready=0. Wrong-path decode is draining.
  - Then return to RUN.
- Simultaneous events:
  - Push and pop in one cycle (correct prediction): both occur; occupancy is unchanged. This is legal even when full, since alloc_ready depends on registered full only.
  - Push and pop with mispredict: the push is discarded.
  - inv_req has priority over everything: queue clears, counter resets to 0, state goes to INIT.
    - An inv_req during INIT restarts the sweep.
    - A resolve in the same cycle as inv_req produces no PHT write and no restore.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and low bits equal; empty = pointers equal.
- rst mid-sweep or mid-operation has the same effect as the reset values above. protocol_err clears only on rst.

Optional Feature:
BP_STATS_EN:
- When defined, adds outputs stat_branches[31:0] and stat_mispred[31:0].
  - stat_branches increments on each RUN-state pop; stat_mispred increments on each mispredict.
  - Both counters saturate at 0xFFFFFFFF, clear on rst, and are unaffected by inv_req.
- When undefined, the ports and counters are absent.

Decomposition:
- Package bp_pkg holds:
  - GHR_LENGTH default
  - counter encodings (SNT=00, WNT=01, WT=11, ST=10)
  - PHT_INIT_VAL=2'b11
  - state enum {INIT, RUN, RECOVER}
  - checkpoint entry struct
- One sub-module, bp_ckpt_fifo: a DEPTH-entry synchronous FIFO with push, pop and clear, where clear has priority.

Test Plan:
- Reset, then hold idle: init_busy=1 and pht_we=1, pht_init=1 for 256 cycles with idx 0..255; then init_busy=0 and alloc_ready=1.
- Push ghr=0x5A, pred=1, pc=0x100, then resolve taken=1: pht_idx=0x5A^0x40=0x1A, pht_taken=1, no restore/flush.
- Push ghr=0x3C, pred=1; push a second entry; resolve taken=0:
  - restore_valid=1, restore_ghr=0x78, flush_req=1 for one cycle.
  - Queue empty, alloc_ready=0 for 1 cycle, then 1.
- Push 4 entries: alloc_ready=0. Push and resolve-correct in the same cycle: accepted, occupancy stays 4. Then 4 resolves leave the queue empty.
- Resolve with an empty queue in RUN: protocol_err=1 sticky, no pht_we. inv_req mid-sweep at idx 100: sweep restarts at idx 0.
- With BP_STATS_EN: 10 resolves including 3 mispredicts give stat_branches=10, stat_mispred=3. Without it, the ports are absent.
